// File: rtl/instr_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package instr_cache_pkg;

  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W   = 6;
  localparam int LINE_W     = LINE_BYTES * 8;

  // Operation code presented on the host read channel.
  typedef enum logic [1:0] {
    HOST_NONE  = 2'b00,
    HOST_READ  = 2'b01,
    HOST_WRITE = 2'b10
  } host_op_e;

  // Miss-handling controller states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQ       = 2'b01,
    ST_WAIT_DONE = 2'b10
  } cache_state_e;

  // Clear the byte offset so the address points at the start of its line.
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return {a[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Tag and valid storage with a single lookup port, one fill port and bulk invalidate.
module icache_tag_array
  import instr_cache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  localparam int INDEX_W  = $clog2(NUM_LINES),
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inv,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_match,
  input  logic               fill_en,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];

  // Valid bits: a bulk invalidate wins over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // Tag storage, written alongside the line data on a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tags[i] <= '0;
      end
    end else if (fill_en) begin
      tags[fill_index] <= fill_tag;
    end
  end

  assign lookup_match = valid[lookup_index] & (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with a single-line fill controller.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   addr,
  input  logic          en,
  input  logic          inv,
  output logic          done,
  output logic          stall,
  output logic [31:0]   data_out,
  output logic          cache_hit,
  input  logic [511:0]  DataIn_host,
  input  logic          rd_valid_host,
  input  logic          tx_done_host,
  output logic [511:0]  DataOut_host,
  output logic [31:0]   AddrOut_host,
  output logic [1:0]    op_host
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;

  cache_state_e       state;
  cache_state_e       state_next;
  host_op_e           op_next;
  logic [31:0]        miss_addr;
  logic [LINE_W-1:0]  data_mem [NUM_LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [3:0]         word;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic               match;
  logic               hit;
  logic               miss;
  logic               fill_en;
  logic               unused_addr_bits;

  assign idx      = addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag      = addr[31:OFFSET_W+INDEX_W];
  assign word     = addr[5:2];
  assign miss_idx = miss_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign miss_tag = miss_addr[31:OFFSET_W+INDEX_W];

  // Byte-within-word bits never select anything in a word-wide fetch.
  assign unused_addr_bits = ^addr[1:0];

  // Lookups only count while idle; an invalidate cycle never hits.
  assign hit     = en & ~inv & match & (state == ST_IDLE);
  assign miss    = en & ~inv & ~match & (state == ST_IDLE);
  // Fill data landing together with an invalidate is dropped.
  assign fill_en = (state == ST_REQ) & rd_valid_host & ~inv;

  icache_tag_array #(
    .NUM_LINES (NUM_LINES)
  ) u_tags (
    .clk          (clk),
    .rst_n        (rst_n),
    .inv          (inv),
    .lookup_index (idx),
    .lookup_tag   (tag),
    .lookup_match (match),
    .fill_en      (fill_en),
    .fill_index   (miss_idx),
    .fill_tag     (miss_tag)
  );

  assign done         = hit;
  assign cache_hit    = hit;
  assign data_out     = hit ? data_mem[idx][{word, 5'b00000} +: 32] : 32'h0;
  assign DataOut_host = '0;
  assign op_host      = op_next;

  // Line data storage; validity is tracked by the tag array so no reset is needed.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[miss_idx] <= DataIn_host;
    end
  end

  // Capture the line address of the access that missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr <= 32'h0;
    end else if (miss) begin
      miss_addr <= line_align(addr);
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, stall and host request decode.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    op_next      = HOST_NONE;
    AddrOut_host = 32'h0;
    case (state)
      ST_IDLE: begin
        if (miss) begin
          stall      = 1'b1;
          state_next = ST_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall        = 1'b1;
        op_next      = HOST_READ;
        AddrOut_host = miss_addr;
        if (tx_done_host) begin
          state_next = ST_IDLE;
        end else if (rd_valid_host) begin
          state_next = ST_WAIT_DONE;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_WAIT_DONE: begin
        stall = 1'b1;
        if (tx_done_host) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
